// File: rtl/tilelink.sv
// TileLink-UL channel definitions shared by pinwheel_core and its bus responders.
package TL;

    localparam int SOURCE_W = 4;
    localparam int SINK_W   = 1;

    // A-channel request opcodes
    localparam logic [2:0] PutFullData    = 3'd0;
    localparam logic [2:0] PutPartialData = 3'd1;
    localparam logic [2:0] Get            = 3'd4;

    // D-channel response opcodes
    localparam logic [2:0] AccessAck      = 3'd0;
    localparam logic [2:0] AccessAckData  = 3'd1;

    typedef struct packed {
        logic [2:0]          a_opcode;
        logic [2:0]          a_size;
        logic [SOURCE_W-1:0] a_source;
        logic [31:0]         a_address;
        logic [3:0]          a_mask;
        logic [31:0]         a_data;
        logic                a_valid;
        logic                a_ready;
    } tilelink_a;

    typedef struct packed {
        logic [2:0]          d_opcode;
        logic [1:0]          d_param;
        logic [2:0]          d_size;
        logic [SOURCE_W-1:0] d_source;
        logic [SINK_W-1:0]   d_sink;
        logic [31:0]         d_data;
        logic                d_error;
        logic                d_valid;
    } tilelink_d;

endpackage

// File: rtl/bytelane_ram.sv
// Word-addressed RAM built from four independent byte lanes; synchronous write
// per lane and an enabled, registered read that holds its value between reads.
module bytelane_ram #(
    parameter int  DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    input  logic          write_en,
    input  logic [3:0]    write_mask,
    input  logic [31:0]   write_data,
    input  logic          read_en,
    output logic [31:0]   read_data
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q;

            always_ff @(posedge clock) begin
                if (write_en && write_mask[gi]) begin
                    lane_mem[addr] <= write_data[gi*8 +: 8];
                end
                if (read_en) begin
                    lane_q <= lane_mem[addr];
                end
            end

            assign read_data[gi*8 +: 8] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/tilelink_ram_responder.sv
// TileLink-UL responder fronting a byte-masked RAM: one request in flight,
// optional wait states between accept and the D-channel response.
module tilelink_ram_responder
    import TL::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic      clock,
    input  logic      reset_in,
    input  tilelink_a tla,
    output logic      a_ready,
    output tilelink_d tld,
    input  logic      d_ready
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WAIT_STATES - 1);
    localparam logic [31:0]      REGION_MASK = ~(32'(DEPTH) * 32'd4 - 32'd1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam state_t ENTRY_STATE = (WAIT_STATES > 0) ? WAIT : RESP;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              get_reg, err_reg;
    logic [2:0]        size_reg;
    logic [SOURCE_W-1:0] source_reg;
    logic [AW-1:0]     index_reg;

    logic          req_get, req_put, req_hit, req_err, accept;
    logic          ram_write, ram_read;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data;
    logic          unused_tla;

    assign req_get = (tla.a_opcode == Get);
    assign req_put = (tla.a_opcode == PutFullData) || (tla.a_opcode == PutPartialData);
    assign req_hit = (tla.a_address & REGION_MASK) == ADDR_BASE;
    assign req_err = !req_hit || (tla.a_size > 3'd2) || !(req_get || req_put);

    assign a_ready = !reset_in && ((state_reg == IDLE) || ((state_reg == RESP) && d_ready));
    assign accept  = tla.a_valid && a_ready;

    // Byte offset is the initiator's concern; the A-side ready bit is ours to drive.
    assign unused_tla = ^{tla.a_ready, tla.a_address[1:0]};

    // Writes land on the accept edge; reads sample on the edge that enters RESP,
    // so the two never share an edge and one RAM port suffices.
    assign ram_write = accept && req_put && !req_err;
    assign ram_read  = (accept && (WAIT_STATES == 0) && req_get && !req_err)
                    || ((state_reg == WAIT) && (cnt_reg == CNT_LAST) && get_reg && !err_reg);
    assign ram_addr  = accept ? tla.a_address[AW+1:2] : index_reg;

    bytelane_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clock      (clock),
        .addr       (ram_addr),
        .write_en   (ram_write),
        .write_mask (tla.a_mask),
        .write_data (tla.a_data),
        .read_en    (ram_read),
        .read_data  (ram_data)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = ENTRY_STATE;
            end
            WAIT: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            RESP: begin
                if (d_ready) state_next = accept ? ENTRY_STATE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            get_reg    <= 1'b0;
            err_reg    <= 1'b0;
            size_reg   <= '0;
            source_reg <= '0;
            index_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                get_reg    <= req_get;
                err_reg    <= req_err;
                size_reg   <= tla.a_size;
                source_reg <= tla.a_source;
                index_reg  <= tla.a_address[AW+1:2];
            end
        end
    end

    // Every D field is gated by RESP so reset forces the whole channel to zero.
    always_comb begin
        tld = '0;
        if (state_reg == RESP) begin
            tld.d_valid  = 1'b1;
            tld.d_opcode = get_reg ? AccessAckData : AccessAck;
            tld.d_size   = size_reg;
            tld.d_source = source_reg;
            tld.d_error  = err_reg;
            tld.d_data   = (get_reg && !err_reg) ? ram_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_tilelink_ram_responder.sv
// Randomised scoreboard bench for tilelink_ram_responder: one instance without
// wait states and one with three, checked against a plain array memory model.
module tb_tilelink_ram_responder;
    import TL::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 16;
    localparam int          NRAND = 40;

    logic      clock    = 1'b0;
    logic      reset_in = 1'b1;
    tilelink_a tla_s [2];
    tilelink_d tld_s [2];
    logic [1:0] a_ready_s, d_ready_s;
    logic [1:0] d_ready_man = 2'b11;
    logic [1:0] d_ready_rnd = 2'b11;
    logic [1:0] rand_ready  = 2'b00;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int rst_events  = 0;
    int acc_cnt       [2];
    int pres_cyc      [2];
    int rise_cyc      [2];
    int last_resp_cyc [2];
    logic [1:0] rise_ready;

    logic [31:0] mem [2][DEPTH];
    tilelink_d exp_q0 [$];
    tilelink_d exp_q1 [$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge reset_in) rst_events <= rst_events + 1;
    always @(posedge clock) begin
        #1;
        d_ready_rnd = 2'($urandom);
    end
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (tla_s[k].a_valid && a_ready_s[k]) acc_cnt[k] <= acc_cnt[k] + 1;
        end
    end

    assign d_ready_s = (rand_ready & d_ready_rnd) | (~rand_ready & d_ready_man);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            tilelink_ram_responder #(
                .ADDR_BASE   (BASE),
                .DEPTH       (DEPTH),
                .WAIT_STATES ((gi == 0) ? 0 : 3)
            ) u_dut (
                .clock    (clock),
                .reset_in (reset_in),
                .tla      (tla_s[gi]),
                .a_ready  (a_ready_s[gi]),
                .tld      (tld_s[gi]),
                .d_ready  (d_ready_s[gi])
            );
        end
    endgenerate

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic qpush(input int k, input tilelink_d d);
        if (k == 0) exp_q0.push_back(d);
        else        exp_q1.push_back(d);
    endtask

    task automatic qpop(input int k, output tilelink_d d);
        if (k == 0) d = exp_q0.pop_front();
        else        d = exp_q1.pop_front();
    endtask

    // Reference: region test by range, legality by opcode list, writes by lane.
    task automatic model_req(input int k, input tilelink_a a, output tilelink_d d);
        bit hit, legal, err;
        int idx;
        hit   = (a.a_address >= BASE) && (a.a_address < BASE + 32'(DEPTH * 4));
        legal = (a.a_opcode == Get) || (a.a_opcode == PutFullData) || (a.a_opcode == PutPartialData);
        err   = !hit || (a.a_size > 3'd2) || !legal;
        idx   = int'((a.a_address - BASE) / 4);
        d          = '0;
        d.d_valid  = 1'b1;
        d.d_size   = a.a_size;
        d.d_source = a.a_source;
        d.d_error  = err;
        d.d_opcode = (a.a_opcode == Get) ? AccessAckData : AccessAck;
        if (!err) begin
            if (a.a_opcode == Get) begin
                d.d_data = mem[k][idx];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (a.a_mask[i]) mem[k][idx][i*8 +: 8] = a.a_data[i*8 +: 8];
                end
            end
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted.
    task automatic send(input int k, input logic [2:0] op, input logic [2:0] size,
                        input logic [3:0] src, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
        tilelink_a a;
        tilelink_d d;
        int  n = 0;
        bit  done = 0;
        a = '0;
        a.a_opcode = op;  a.a_size = size; a.a_source = src;
        a.a_address = addr; a.a_mask = mask; a.a_data = data; a.a_valid = 1'b1;
        tla_s[k] = a;
        while (!done) begin
            @(negedge clock);
            if (a_ready_s[k]) begin
                model_req(k, a, d);
                qpush(k, d);
                pres_cyc[k] = cyc;
                done = 1;
            end else if (++n > 50) begin
                check("a_ready_timeout", 64'(a_ready_s[k]), 64'd1);
                done = 1;
            end
            @(posedge clock);
            #1;
        end
        tla_s[k].a_valid = 1'b0;
    endtask

    task automatic send_random(input int k);
        logic [2:0]  op, size;
        logic [31:0] addr;
        case ($urandom_range(0, 9))
            0:       op = 3'($urandom);
            1, 2, 3: op = PutFullData;
            4, 5:    op = PutPartialData;
            default: op = Get;
        endcase
        size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        case ($urandom_range(0, 9))
            0:       addr = $urandom;
            1:       addr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
            default: addr = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
        endcase
        send(k, op, size, 4'($urandom), addr, 4'($urandom), $urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic monitor();
        tilelink_d  prev_tld [2];
        tilelink_d  cur, exp;
        logic [1:0] prev_stall = '0;
        logic [1:0] prev_valid = '0;
        int         rst_seen   = 0;
        forever begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                cur = tld_s[k];
                if (prev_stall[k] && (rst_seen == rst_events))
                    check("d_hold", 64'(cur), 64'(prev_tld[k]));
                if (cur.d_valid && !prev_valid[k]) begin
                    rise_cyc[k]   = cyc;
                    rise_ready[k] = a_ready_s[k];
                end
                if (cur.d_valid && d_ready_s[k]) begin
                    if (qsize(k) == 0) begin
                        check("unexpected_d", 64'(cur.d_valid), 64'd0);
                    end else begin
                        qpop(k, exp);
                        check($sformatf("d_resp%0d", k), 64'(cur), 64'(exp));
                        last_resp_cyc[k] = cyc;
                    end
                end
                prev_stall[k] = cur.d_valid && !d_ready_s[k];
                prev_valid[k] = cur.d_valid;
                prev_tld[k]   = cur;
            end
            rst_seen = rst_events;
        end
    endtask

    initial begin
        int p;
        tilelink_a hold;
        tla_s[0] = '0;
        tla_s[1] = '0;
        fork
            monitor();
        join_none

        // Reset state
        idle(2);
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            check("reset_tld", 64'(tld_s[k]), 64'd0);
            check("reset_a_ready", 64'(a_ready_s[k]), 64'd0);
        end
        @(posedge clock); #1;
        reset_in = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 2; k++) check("idle_a_ready", 64'(a_ready_s[k]), 64'd1);
        @(posedge clock); #1;

        // Give both RAMs known contents
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < DEPTH; w++)
                send(k, PutFullData, 3'd2, 4'd0, BASE + 32'(w * 4), 4'hF, $urandom);

        // Full put, partial put, readback
        for (int k = 0; k < 2; k++) begin
            send(k, PutFullData,    3'd2, 4'd0, BASE + 32'd4, 4'hF, 32'h1122_3344);
            send(k, PutPartialData, 3'd2, 4'd0, BASE + 32'd4, 4'h3, 32'hAABB_CCDD);
            send(k, Get,            3'd2, 4'd1, BASE + 32'd4, 4'h0, 32'd0);
        end
        idle(8);

        // Latency: 1 cycle without wait states, 4 with three
        for (int k = 0; k < 2; k++) begin
            rise_cyc[k] = -1;
            send(k, Get, 3'd2, 4'd2, BASE + 32'd8, 4'hF, 32'd0);
            p = pres_cyc[k];
            idle(8);
            check($sformatf("latency%0d", k), 64'(rise_cyc[k] - p), (k == 0) ? 64'd1 : 64'd4);
            check($sformatf("a_ready_in_resp%0d", k), 64'(rise_ready[k]), 64'd1);
        end

        // Stall: response held, no second accept
        d_ready_man[0] = 1'b0;
        p = acc_cnt[0];
        send(0, Get, 3'd2, 4'd3, BASE + 32'd12, 4'hF, 32'd0);
        hold = '0;
        hold.a_opcode = PutFullData; hold.a_size = 3'd2; hold.a_address = BASE + 32'd12;
        hold.a_mask = 4'hF; hold.a_data = 32'hFFFF_FFFF; hold.a_valid = 1'b1;
        tla_s[0] = hold;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_a_ready", 64'(a_ready_s[0]), 64'd0);
            check("stall_d_valid", 64'(tld_s[0].d_valid), 64'd1);
            @(posedge clock); #1;
        end
        check("stall_accepts", 64'(acc_cnt[0] - p), 64'd1);
        tla_s[0].a_valid = 1'b0;
        d_ready_man[0] = 1'b1;
        idle(4);

        // Eight back-to-back Gets in nine cycles
        send(0, Get, 3'd2, 4'd4, BASE, 4'hF, 32'd0);
        p = pres_cyc[0];
        for (int i = 1; i < 8; i++)
            send(0, Get, 3'(i % 3), 4'(i), BASE + 32'(i * 4), 4'hF, 32'd0);
        idle(4);
        check("b2b_cycles", 64'(last_resp_cyc[0] - p + 1), 64'd9);

        // Errors leave RAM unchanged
        for (int k = 0; k < 2; k++) begin
            send(k, PutFullData, 3'd2, 4'd5, BASE + 32'(DEPTH * 4), 4'hF, 32'hDEAD_BEEF);
            send(k, PutFullData, 3'd3, 4'd6, BASE + 32'd16, 4'hF, 32'hDEAD_BEEF);
            send(k, 3'd2,        3'd2, 4'd7, BASE + 32'd20, 4'hF, 32'hDEAD_BEEF);
            send(k, Get,         3'd3, 4'd8, BASE + 32'd16, 4'hF, 32'd0);
            send(k, Get,         3'd2, 4'd9, BASE - 32'd4,  4'hF, 32'd0);
            send(k, Get,         3'd2, 4'd10, BASE,          4'hF, 32'd0);
            send(k, Get,         3'd2, 4'd11, BASE + 32'd16, 4'hF, 32'd0);
            send(k, Get,         3'd2, 4'd12, BASE + 32'd20, 4'hF, 32'd0);
        end
        idle(8);

        // Reset while a response is waiting on d_ready
        d_ready_man[0] = 1'b0;
        send(0, Get, 3'd2, 4'd13, BASE + 32'd24, 4'hF, 32'd0);
        #1;
        check("pre_reset_d_valid", 64'(tld_s[0].d_valid), 64'd1);
        #1;
        reset_in = 1'b1;
        #1;
        check("mid_reset_tld", 64'(tld_s[0]), 64'd0);
        check("mid_reset_a_ready0", 64'(a_ready_s[0]), 64'd0);
        check("mid_reset_a_ready1", 64'(a_ready_s[1]), 64'd0);
        exp_q0.delete();
        @(posedge clock); #1;
        reset_in = 1'b0;
        @(negedge clock);
        check("post_reset_a_ready", 64'(a_ready_s[0]), 64'd1);
        @(posedge clock); #1;
        d_ready_man[0] = 1'b1;

        // Reset during WAIT drops the request
        rise_cyc[1] = -1;
        send(1, Get, 3'd2, 4'd14, BASE + 32'd28, 4'hF, 32'd0);
        #1;
        reset_in = 1'b1;
        exp_q1.delete();
        @(posedge clock); #1;
        reset_in = 1'b0;
        idle(8);
        check("no_resp_after_reset", 64'(rise_cyc[1]), 64'(-1));
        send(1, Get, 3'd2, 4'd15, BASE + 32'd28, 4'hF, 32'd0);
        send(0, Get, 3'd2, 4'd15, BASE + 32'd24, 4'hF, 32'd0);
        idle(8);

        // Random traffic with random d_ready back-pressure
        rand_ready = 2'b11;
        for (int i = 0; i < NRAND; i++) begin
            send_random(0);
            send_random(1);
        end
        rand_ready = 2'b00;
        d_ready_man = 2'b11;
        idle(10);

        check("pending_responses", 64'(qsize(0) + qsize(1)), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
